// File: rtl/screen_sequencer.sv
// Game-flow controller: welcome -> pause/play -> game over -> welcome, with
// lives bookkeeping, frame-timed pauses and a one-cycle object reset pulse.
module screen_sequencer #(
  parameter int LIVES               = 3,
  parameter int PAUSE_FRAMES        = 60,
  parameter int GAMEOVER_FRAMES     = 180,
  parameter int MIN_GAMEOVER_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       playerHit,
  input  logic       levelCleared,
  output logic [1:0] selector,
  output logic       playEnable,
  output logic       objectsReset,
  output logic [2:0] livesLeft,
  output logic       gameWon
);

  typedef enum logic [1:0] {WELCOME, PAUSE, PLAY, GAMEOVER} state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] PAUSE_N    = 8'(PAUSE_FRAMES);
  localparam logic [7:0] GOVER_N    = 8'(GAMEOVER_FRAMES);
  localparam logic [7:0] GOVER_MIN  = 8'(MIN_GAMEOVER_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       armed_q, armed_d;
  logic [2:0] lives_q, lives_d;
  logic       won_q, won_d;
  logic [1:0] sel_q, sel_d;
  logic       play_q, play_d;
  logic       ores_q, ores_d;
  logic       key_press;

  assign key_press = startKey & armed_q;
  // Value the counter reaches on this frame pulse; the transition fires on it.
  assign cnt_inc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    won_d   = won_q;
    ores_d  = 1'b0;
    armed_d = armed_q | ~startKey;
    unique case (state_q)
      WELCOME: begin
        if (key_press) begin
          armed_d = 1'b0;
          ores_d  = 1'b1;
          lives_d = LIVES_INIT;
          won_d   = 1'b0;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (startOfFrame && cnt_inc == PAUSE_N) state_d = PLAY;
      end
      PLAY: begin
        if (levelCleared) begin
          won_d   = 1'b1;
          state_d = GAMEOVER;
        end else if (playerHit) begin
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = GAMEOVER;
          end else begin
            lives_d = lives_q - 3'd1;
            ores_d  = 1'b1;
            state_d = PAUSE;
          end
        end
      end
      GAMEOVER: begin
        // An early press is swallowed so a held key cannot skip later.
        if (key_press) armed_d = 1'b0;
        if (startOfFrame && cnt_inc == GOVER_N)      state_d = WELCOME;
        else if (key_press && cnt_q >= GOVER_MIN)    state_d = WELCOME;
      end
      default: state_d = WELCOME;
    endcase

    if (state_d != state_q)  cnt_d = 8'd0;
    else if (startOfFrame)   cnt_d = cnt_inc;
    else                     cnt_d = cnt_q;

    sel_d  = (state_d == GAMEOVER) ? 2'd2 : (state_d == WELCOME) ? 2'd0 : 2'd1;
    play_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WELCOME;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      lives_q <= LIVES_INIT;
      won_q   <= 1'b0;
      sel_q   <= 2'd0;
      play_q  <= 1'b0;
      ores_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      lives_q <= lives_d;
      won_q   <= won_d;
      sel_q   <= sel_d;
      play_q  <= play_d;
      ores_q  <= ores_d;
    end
  end

  assign selector     = sel_q;
  assign playEnable   = play_q;
  assign objectsReset = ores_q;
  assign livesLeft    = lives_q;
  assign gameWon      = won_q;

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level game-flow controller. Produces the 2-bit screen selector consumed by the display multiplexer: 0 = welcome, 1 = play mode, 2 = game over. Value 3 is never driven.
- Runs the welcome → play → game-over → welcome cycle.
- Keeps the lives count and handles respawn pauses.
- Counts frames to time the pause and game-over screens.
- Emits a one-cycle reset pulse to the game objects whenever a new game or respawn starts.

Parameters:
- LIVES, 3, lives at game start (1..7).
- PAUSE_FRAMES, 60, frames play is frozen after a new game starts or after a hit (1..255).
- GAMEOVER_FRAMES, 180, frames the game-over screen is shown before auto-return to welcome (1..255).
- MIN_GAMEOVER_FRAMES, 30, frames before startKey may skip the game-over screen (< GAMEOVER_FRAMES).

Ports:
- clk, input, 1, system clock (pixel clock domain).
- reset, input, 1, synchronous active-high reset.
- startOfFrame, input, 1, one-cycle pulse per video frame.
- startKey, input, 1, debounced level of the start key (1 = pressed).
- playerHit, input, 1, one-cycle pulse when the player is hit.
- levelCleared, input, 1, one-cycle pulse when all bubbles are destroyed.
- selector, output, 2, screen select to the display mux.
- playEnable, output, 1, high when game objects may move.
- objectsReset, output, 1, one-cycle pulse that re-initialises game objects.
- livesLeft, output, 3, remaining lives, for the score/info overlay.
- gameWon, output, 1, high on the game-over screen if the game ended by levelCleared.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state = WELCOME, selector = 0, playEnable = 0, objectsReset = 0.
  - livesLeft = LIVES, gameWon = 0, frame counter = 0.
  - Key-armed flag = 0, so the key must be released after reset before a press is accepted.
- Key press detection:
  - keyPress = startKey & keyArmed.
  - keyArmed is set one cycle after startKey is seen low.
  - keyArmed is cleared whenever keyPress is acted on.
  - A key held across a state change never triggers twice.
- Frame counter:
  - 8-bit, clears on every state entry.
  - Increments on startOfFrame and saturates at 255.
- States (selector / playEnable):
  - WELCOME (0/0): on keyPress →
    - objectsReset pulse in the transition cycle;
    - livesLeft = LIVES, gameWon = 0;
    - go to PAUSE.
  - PAUSE (1/0): when counter == PAUSE_FRAMES at a startOfFrame → PLAY.
  - PLAY (1/1), checked in priority order:
    1. levelCleared → gameWon = 1, go to GAMEOVER.
    2. playerHit with livesLeft == 1 → livesLeft = 0, go to GAMEOVER.
    3. playerHit otherwise → livesLeft decrements, objectsReset pulse, go to PAUSE.
  - Simultaneous levelCleared and playerHit: levelCleared wins and livesLeft is unchanged.
  - GAMEOVER (2/0):
    - Go to WELCOME when counter == GAMEOVER_FRAMES at a startOfFrame.
    - Also go to WELCOME on keyPress once counter ≥ MIN_GAMEOVER_FRAMES.
    - An earlier keyPress is ignored but still consumes keyArmed.
- Ignored inputs:
  - playerHit and levelCleared are ignored outside PLAY.
  - startKey is ignored in PAUSE and PLAY; keyArmed still tracks release.
- Timing:
  - All outputs are registered.
  - selector and playEnable change in the cycle after the triggering input.
  - objectsReset is high for exactly that one cycle.
- The pause length counts startOfFrame pulses, not clocks. A pulse coincident with state entry is not counted.
- livesLeft never underflows. gameWon holds until the next game starts.

Test Plan:
- Reset held for 3 cycles with startKey = 1 → selector = 0, livesLeft = 3. Holding the key never starts a game; release then press → objectsReset is a single 1-cycle pulse and selector = 1 on the next cycle.
- After start, pulse startOfFrame 60 times → playEnable rises the cycle after the 60th pulse. There is no early rise at the 59th.
- In PLAY, 3 playerHit pulses, each followed by a pause → livesLeft goes 3→2→1→0. The 3rd hit gives selector = 2, gameWon = 0, and no objectsReset.
- levelCleared and playerHit in the same cycle with livesLeft = 2 → selector = 2, gameWon = 1, livesLeft stays 2.
- GAMEOVER with keyPress after 10 frames → no exit. Release and press after 30 frames → selector = 0. With no key press → return to welcome after exactly 180 frames.
- reset asserted mid-PLAY while startKey is held → next cycle selector = 0, playEnable = 0, livesLeft = 3, and the held key does not start a game.
